// File: rtl/usb11_recv.sv
// Full-speed USB 1.1 receiver: oversampled line recovery, NRZI decode,
// bit unstuffing, SYNC/EOP framing and byte delivery.
module usb11_recv #(
   parameter int OVS            = 5,
   parameter int SAMPLE_PHASE   = 2,
   parameter int SYNC_ZEROS_MIN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dp,
   input  logic       dm,
   input  logic       rx_ena,
   output logic [7:0] rbyte,
   output logic       rbyte_wr,
   output logic       pkt_start,
   output logic       pkt_end,
   output logic       err_stuff,
   output logic       err_align,
   output logic [1:0] line_state
);

   localparam int PW = (OVS > 1) ? $clog2(OVS) : 1;

   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_SE1 = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_EOP,
      S_WAIT
   } state_t;

   state_t state_q, state_d;

   logic [1:0]    meta_q, meta_d;
   logic [1:0]    ls_q, ls_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [1:0]    prev_q, prev_d;
   logic [3:0]    zcnt_q, zcnt_d;
   logic [2:0]    ones_q, ones_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          jcnt_q, jcnt_d;
   logic [7:0]    rbyte_q, rbyte_d;
   logic          rbyte_wr_q, rbyte_wr_d;
   logic          pkt_start_q, pkt_start_d;
   logic          pkt_end_q, pkt_end_d;
   logic          err_stuff_q, err_stuff_d;
   logic          err_align_q, err_align_d;

   logic tick;
   logic is_j;
   logic is_k;
   logic is_se0;
   logic is_se1;
   logic lvl;
   logic dbit;
   logic stuff_pos;
   logic stuff_err;
   logic sync_ok;

   assign tick      = (phase_q == PW'(SAMPLE_PHASE));
   assign is_j      = (ls_q == LS_J);
   assign is_k      = (ls_q == LS_K);
   assign is_se0    = (ls_q == LS_SE0);
   assign is_se1    = (ls_q == LS_SE1);
   assign lvl       = is_j | is_k;
   assign dbit      = (ls_q == prev_q);
   assign stuff_pos = (ones_q == 3'd6);
   assign stuff_err = stuff_pos & dbit & lvl;
   assign sync_ok   = (zcnt_q >= 4'(SYNC_ZEROS_MIN));

   // Phase restarts on every line edge so ticks stay centred in the bit
   always_comb begin
      meta_d = {dp, dm};
      ls_d   = meta_q;
      if (meta_q != ls_q) begin
         phase_d = '0;
      end else if (phase_q == PW'(OVS - 1)) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (is_k) state_d = S_SYNC;
            end
            S_SYNC: begin
               if (!lvl) begin
                  state_d = S_IDLE;
               end else if (dbit) begin
                  state_d = sync_ok ? S_DATA : S_IDLE;
               end else if (zcnt_q >= 4'd8) begin
                  state_d = S_IDLE;
               end
            end
            S_DATA: begin
               if (is_se0) begin
                  state_d = S_EOP;
               end else if (is_se1 || stuff_err) begin
                  state_d = S_WAIT;
               end
            end
            S_EOP: begin
               if (is_j) begin
                  state_d = S_IDLE;
               end else if (!is_se0) begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (is_j && jcnt_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (!rx_ena) state_d = S_IDLE;
   end

   always_comb begin
      prev_d      = prev_q;
      zcnt_d      = zcnt_q;
      ones_d      = ones_q;
      bcnt_d      = bcnt_q;
      shift_d     = shift_q;
      jcnt_d      = 1'b0;
      rbyte_d     = rbyte_q;
      rbyte_wr_d  = 1'b0;
      pkt_start_d = 1'b0;
      pkt_end_d   = 1'b0;
      err_stuff_d = 1'b0;
      err_align_d = 1'b0;

      if (tick && lvl) prev_d = ls_q;

      case (state_q)
         S_IDLE: begin
            if (tick && is_k) zcnt_d = 4'd1;
         end
         S_SYNC: begin
            if (tick && lvl && !dbit) begin
               zcnt_d = zcnt_q + 4'd1;
            end
            if (tick && lvl && dbit && sync_ok) begin
               pkt_start_d = 1'b1;
               bcnt_d      = 3'd0;
               ones_d      = 3'd0;
            end
         end
         S_DATA: begin
            if (tick && lvl) begin
               if (stuff_pos) begin
                  ones_d      = 3'd0;
                  pkt_end_d   = dbit;
                  err_stuff_d = dbit;
               end else begin
                  ones_d  = dbit ? ones_q + 3'd1 : 3'd0;
                  shift_d = {dbit, shift_q[7:1]};
                  bcnt_d  = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) begin
                     rbyte_d    = {dbit, shift_q[7:1]};
                     rbyte_wr_d = 1'b1;
                  end
               end
            end
            if (tick && is_se1) pkt_end_d = 1'b1;
         end
         S_EOP: begin
            if (tick && is_j) begin
               pkt_end_d   = 1'b1;
               err_align_d = (bcnt_q != 3'd0);
            end else if (tick && !is_se0) begin
               pkt_end_d = 1'b1;
            end
         end
         S_WAIT: begin
            jcnt_d = tick ? is_j : jcnt_q;
         end
         default: ;
      endcase

      if (state_d == S_IDLE) prev_d = LS_J;

      // Receiver muted: drop the packet without any strobe
      if (!rx_ena) begin
         rbyte_d     = rbyte_q;
         rbyte_wr_d  = 1'b0;
         pkt_start_d = 1'b0;
         pkt_end_d   = 1'b0;
         err_stuff_d = 1'b0;
         err_align_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q      <= LS_J;
         ls_q        <= LS_J;
         phase_q     <= '0;
         prev_q      <= LS_J;
         zcnt_q      <= 4'd0;
         ones_q      <= 3'd0;
         bcnt_q      <= 3'd0;
         shift_q     <= 8'd0;
         jcnt_q      <= 1'b0;
         rbyte_q     <= 8'd0;
         rbyte_wr_q  <= 1'b0;
         pkt_start_q <= 1'b0;
         pkt_end_q   <= 1'b0;
         err_stuff_q <= 1'b0;
         err_align_q <= 1'b0;
      end else begin
         meta_q      <= meta_d;
         ls_q        <= ls_d;
         phase_q     <= phase_d;
         prev_q      <= prev_d;
         zcnt_q      <= zcnt_d;
         ones_q      <= ones_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         jcnt_q      <= jcnt_d;
         rbyte_q     <= rbyte_d;
         rbyte_wr_q  <= rbyte_wr_d;
         pkt_start_q <= pkt_start_d;
         pkt_end_q   <= pkt_end_d;
         err_stuff_q <= err_stuff_d;
         err_align_q <= err_align_d;
      end
   end

   assign rbyte      = rbyte_q;
   assign rbyte_wr   = rbyte_wr_q;
   assign pkt_start  = pkt_start_q;
   assign pkt_end    = pkt_end_q;
   assign err_stuff  = err_stuff_q;
   assign err_align  = err_align_q;
   assign line_state = ls_q;

endmodule
